// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver, inputs oversampled in sysClk domain.
// Optional MISO transmit path is compiled in when SPI_TX_EN is defined.
module spi_slave_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic       sysClk,
  input  logic       sysRst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       rx_abort,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall;
  logic w_cs_rise, w_cs_fall;

  // CS sync resets low so a CS already low at release never looks like a fall
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_bit_cnt, w_bit_nx;
  logic [TO_W-1:0] r_to_cnt, w_to_nx;
  logic [7:0]      r_rx_shift, w_shift_nx;
  logic [7:0]      r_rx_byte, w_byte_nx;
  logic            r_rx_valid, w_valid_nx;
  logic            r_frame_start, w_fs_nx;
  logic            r_frame_end, w_fe_nx;
  logic            r_rx_abort, w_abort_nx;
  logic            w_byte_done;
  logic            w_start;
  logic            w_timeout;

  assign w_start   = (r_state == S_IDLE) && w_cs_fall;
  assign w_timeout = !(w_sck_rise || w_sck_fall) && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nx  = r_state;
    w_bit_nx    = r_bit_cnt;
    w_to_nx     = r_to_cnt;
    w_shift_nx  = r_rx_shift;
    w_byte_nx   = r_rx_byte;
    w_valid_nx  = 1'b0;
    w_fs_nx     = 1'b0;
    w_fe_nx     = 1'b0;
    w_abort_nx  = 1'b0;
    w_byte_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nx = S_SHIFT;
          w_fs_nx    = 1'b1;
          w_bit_nx   = 3'd0;
          w_to_nx    = '0;
        end
      end
      S_SHIFT: begin
        if (w_sck_rise) begin
          w_shift_nx = {r_rx_shift[6:0], w_mosi_s};
          w_bit_nx   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_byte_nx   = {r_rx_shift[6:0], w_mosi_s};
            w_valid_nx  = 1'b1;
            w_byte_done = 1'b1;
          end
        end
        if (w_sck_rise || w_sck_fall) begin
          w_to_nx = '0;
        end else if (!w_timeout) begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
        // a byte completing on the same cycle as CS rise is still accepted
        if (w_cs_rise) begin
          w_state_nx = S_IDLE;
          w_fe_nx    = 1'b1;
          w_abort_nx = (w_bit_nx != 3'd0);
        end else if (w_timeout) begin
          w_state_nx = S_STALL;
          w_abort_nx = (r_bit_cnt != 3'd0);
        end
      end
      S_STALL: begin
        if (w_cs_rise) begin
          w_state_nx = S_IDLE;
          w_fe_nx    = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd0;
      r_to_cnt      <= '0;
      r_rx_shift    <= 8'h00;
      r_rx_byte     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_rx_abort    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_bit_cnt     <= w_bit_nx;
      r_to_cnt      <= w_to_nx;
      r_rx_shift    <= w_shift_nx;
      r_rx_byte     <= w_byte_nx;
      r_rx_valid    <= w_valid_nx;
      r_frame_start <= w_fs_nx;
      r_frame_end   <= w_fe_nx;
      r_rx_abort    <= w_abort_nx;
    end
  end

  assign rx_byte     = r_rx_byte;
  assign rx_valid    = r_rx_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign rx_abort    = r_rx_abort;

`ifdef SPI_TX_EN
  logic [7:0] r_tx_hold;
  logic [7:0] r_tx_shift;
  logic       r_tx_full;
  logic       r_tx_reload;
  logic       r_tx_under;
  logic       w_tx_take;

  // reload at frame start, and on the first SCK fall after a byte completes
  assign w_tx_take = w_start ||
    ((r_state == S_SHIFT) && r_tx_reload && w_sck_fall);

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_tx_hold   <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_tx_full   <= 1'b0;
      r_tx_reload <= 1'b0;
      r_tx_under  <= 1'b0;
    end else begin
      r_tx_under <= 1'b0;
      if (w_start) begin
        r_tx_reload <= 1'b0;
      end else if (w_byte_done) begin
        r_tx_reload <= 1'b1;
      end else if (w_tx_take) begin
        r_tx_reload <= 1'b0;
      end
      if (w_tx_take) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_hold;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= 8'h00;
          r_tx_under <= 1'b1;
        end
      end else if ((r_state == S_SHIFT) && w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      if (tx_load && !r_tx_full) begin
        r_tx_hold <= tx_byte;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign spi_miso    = (r_state == S_SHIFT) && r_tx_shift[7];
  assign tx_ready    = ~r_tx_full;
  assign tx_underrun = r_tx_under;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^{tx_byte, tx_load, w_byte_done, w_start};
  assign spi_miso    = 1'b0;
  assign tx_ready    = 1'b0;
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: table-driven, hand-written and random frames for spi_slave_rx.
// Expected bytes come from slicing the sent bit stream into groups of eight.
module tb_spi_slave_rx;

  logic       sysClk   = 1'b0;
  logic       sysRst_n = 1'b0;
  logic       spi_sck  = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_start;
  logic       frame_end;
  logic       rx_abort;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_load  = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;

`ifdef SPI_TX_EN
  localparam logic        EXP_RDY_RST  = 1'b1;
  localparam logic        EXP_RDY_LOAD = 1'b0;
  localparam logic        EXP_RDY_END  = 1'b1;
  localparam logic [15:0] EXP_MISO     = 16'h3C00;
  localparam int          EXP_UN       = 2;
`else
  localparam logic        EXP_RDY_RST  = 1'b0;
  localparam logic        EXP_RDY_LOAD = 1'b0;
  localparam logic        EXP_RDY_END  = 1'b0;
  localparam logic [15:0] EXP_MISO     = 16'h0000;
  localparam int          EXP_UN       = 0;
`endif

  spi_slave_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(4096),
    .TO_W          (12)
  ) dut (
    .sysClk     (sysClk),
    .sysRst_n   (sysRst_n),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_abort   (rx_abort),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun)
  );

  always #5 sysClk = ~sysClk;

  int n_assert = 0;
  int n_fail   = 0;

  int         tot_fs = 0, tot_fe = 0, tot_ab = 0, tot_un = 0;
  logic [7:0] q_rx[$];
  int         b_fs, b_fe, b_ab, b_un, b_rx;
  logic       q_miso[$];
  logic [7:0] m_last = 8'h00;

  always @(negedge sysClk) begin
    if (rx_valid)    q_rx.push_back(rx_byte);
    if (frame_start) tot_fs++;
    if (frame_end)   tot_fe++;
    if (rx_abort)    tot_ab++;
    if (tx_underrun) tot_un++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mark();
    b_fs = tot_fs;
    b_fe = tot_fe;
    b_ab = tot_ab;
    b_un = tot_un;
    b_rx = q_rx.size();
    q_miso.delete();
  endtask

  // mode 0 master: MOSI set while SCK low, master samples MISO at SCK rise
  task automatic spi_xfer(input int n, input logic [71:0] d,
                          input int hp, input bit close);
    spi_cs_n = 1'b0;
    #100;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = d[i];
      #(hp);
      q_miso.push_back(spi_miso);
      spi_sck = 1'b1;
      #(hp);
      spi_sck = 1'b0;
    end
    #(hp);
    if (close) begin
      spi_cs_n = 1'b1;
      #200;
    end
  endtask

  task automatic check_frame(input string nm, input int n, input logic [71:0] d,
                             input int exp_bytes, input bit exp_abort);
    int          nb;
    logic [71:0] t;
    nb = n / 8;
    chk({nm, "_nbytes"}, 72'(q_rx.size() - b_rx), 72'(exp_bytes));
    for (int b = 0; b < nb; b++) begin
      t = d >> (n - 8 * (b + 1));
      if (b_rx + b < q_rx.size())
        chk($sformatf("%s_byte%0d", nm, b), 72'(q_rx[b_rx + b]), 72'(t[7:0]));
      m_last = t[7:0];
    end
    chk({nm, "_fs"}, 72'(tot_fs - b_fs), 72'(1));
    chk({nm, "_fe"}, 72'(tot_fe - b_fe), 72'(1));
    chk({nm, "_abort"}, 72'(tot_ab - b_ab), 72'(exp_abort));
    chk({nm, "_hold"}, 72'(rx_byte), 72'(m_last));
  endtask

  typedef struct {
    int          nbits;
    logic [71:0] data;
    int          exp_bytes;
    bit          exp_abort;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] mb;
    int          n;
    int          hp;
    logic [71:0] d;

    vecs[0] = '{8,  72'hA5, 1, 1'b0};
    vecs[1] = '{72, 72'h07_11_22_33_44_55_66_77_88, 9, 1'b0};
    vecs[2] = '{5,  72'h1F, 0, 1'b1};
    vecs[3] = '{8,  72'h3C, 1, 1'b0};
    vecs[4] = '{16, 72'h00FF, 2, 1'b0};
    vecs[5] = '{0,  72'h00, 0, 1'b0};
    vecs[6] = '{15, 72'h5A3B, 1, 1'b1};

    #3;
    #30;
    sysRst_n = 1'b1;
    #100;
    chk("rst_rx_byte", 72'(rx_byte), 72'(8'h00));
    chk("rst_rx_valid", 72'(rx_valid), 72'(0));
    chk("rst_miso", 72'(spi_miso), 72'(0));
    chk("rst_tx_ready", 72'(tx_ready), 72'(EXP_RDY_RST));
    chk("rst_strobes", 72'({frame_start, frame_end, rx_abort, tx_underrun}), 72'(0));

    for (int v = 0; v < 7; v++) begin
      mark();
      spi_xfer(vecs[v].nbits, vecs[v].data, 50, 1'b1);
      check_frame($sformatf("vec%0d", v), vecs[v].nbits, vecs[v].data,
                  vecs[v].exp_bytes, vecs[v].exp_abort);
    end

    // last SCK rise and CS rise in the same instant
    mark();
    spi_xfer(7, 72'h73, 50, 1'b0);
    spi_mosi = 1'b1;
    #50;
    spi_sck  = 1'b1;
    spi_cs_n = 1'b1;
    #50;
    spi_sck = 1'b0;
    #200;
    check_frame("simul", 8, 72'hE7, 1, 1'b0);

    // SCK stall mid-byte
    mark();
    spi_xfer(3, 72'h5, 50, 1'b0);
    #(4200 * 10);
    chk("to_abort", 72'(tot_ab - b_ab), 72'(1));
    chk("to_fe", 72'(tot_fe - b_fe), 72'(0));
    chk("to_nbytes", 72'(q_rx.size() - b_rx), 72'(0));
    spi_xfer(8, 72'hFF, 50, 1'b0);
    chk("stall_nbytes", 72'(q_rx.size() - b_rx), 72'(0));
    spi_cs_n = 1'b1;
    #200;
    chk("stall_fe", 72'(tot_fe - b_fe), 72'(1));
    chk("stall_abort", 72'(tot_ab - b_ab), 72'(1));
    chk("stall_hold", 72'(rx_byte), 72'(m_last));
    mark();
    spi_xfer(8, 72'h5A, 50, 1'b1);
    check_frame("post_stall", 8, 72'h5A, 1, 1'b0);

    // reset in the middle of a byte with CS held low
    mark();
    spi_xfer(4, 72'hA, 50, 1'b0);
    sysRst_n = 1'b0;
    #1;
    chk("mrst_rx_byte", 72'(rx_byte), 72'(8'h00));
    chk("mrst_strobes", 72'({rx_valid, frame_start, frame_end, rx_abort}), 72'(0));
    chk("mrst_miso", 72'(spi_miso), 72'(0));
    chk("mrst_tx_ready", 72'(tx_ready), 72'(EXP_RDY_RST));
    #19;
    sysRst_n = 1'b1;
    m_last = 8'h00;
    #100;
    mark();
    spi_xfer(8, 72'hA5, 50, 1'b0);
    chk("mrst_nbytes", 72'(q_rx.size() - b_rx), 72'(0));
    chk("mrst_fs", 72'(tot_fs - b_fs), 72'(0));
    spi_cs_n = 1'b1;
    #200;
    chk("mrst_fe", 72'(tot_fe - b_fe), 72'(0));
    chk("mrst_hold", 72'(rx_byte), 72'(m_last));
    mark();
    spi_xfer(8, 72'h96, 50, 1'b1);
    check_frame("post_rst", 8, 72'h96, 1, 1'b0);

    // transmit: 0x3C loaded, second load ignored, then underrun
    mark();
    tx_byte = 8'h3C;
    tx_load = 1'b1;
    #10;
    tx_byte = 8'h99;
    #10;
    tx_load = 1'b0;
    #10;
    chk("tx_ready_load", 72'(tx_ready), 72'(EXP_RDY_LOAD));
    spi_xfer(16, 72'h5AC3, 50, 1'b1);
    chk("tx_nbits", 72'(q_miso.size()), 72'(16));
    mb = 16'h0000;
    for (int i = 0; i < 16 && i < q_miso.size(); i++)
      mb = {mb[14:0], q_miso[i]};
    chk("tx_miso", 72'(mb), 72'(EXP_MISO));
    chk("tx_underrun", 72'(tot_un - b_un), 72'(EXP_UN));
    chk("tx_ready_end", 72'(tx_ready), 72'(EXP_RDY_END));
    check_frame("txrx", 16, 72'h5AC3, 2, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n  = int'($urandom_range(0, 64));
      hp = 10 * int'($urandom_range(4, 8));
      d  = {8'h00, $urandom, $urandom};
      mark();
      spi_xfer(n, d, hp, 1'b1);
      check_frame($sformatf("rnd%0d", r), n, d, n / 8, (n % 8) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
